// File: rtl/issue_queue_pkg.sv
// ============================================================================
// issue_queue_pkg
// Shared helpers for the out-of-order issue queue: wide ID type and the
// modular age comparison used by oldest-first selection and flush kill.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_queue_pkg;

  // IDs of any configured width are zero-extended into this type before
  // comparison so one function serves every ID_W up to 32.
  localparam int unsigned IQ_ID_MAX_W = 32;

  typedef logic [IQ_ID_MAX_W-1:0] iq_id_wide_t;

  // a is older than b when the top bit (of an id_w-bit field) of a-b is set.
  // The low id_w bits of a 32-bit subtraction equal the id_w-bit modular
  // difference, so extending the operands does not change the answer.
  function automatic logic id_older(input iq_id_wide_t a,
                                    input iq_id_wide_t b,
                                    input int unsigned id_w);
    iq_id_wide_t diff;
    iq_id_wide_t shifted;
    diff    = a - b;
    shifted = diff >> (id_w - 1);
    return shifted[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/issue_queue_age_select.sv
// ============================================================================
// iq_age_select
// Combinational grant logic for the issue queue. With
// ISSUE_QUEUE_AGE_SELECT_EN defined the oldest selectable entry wins (modular
// ID age); otherwise a fixed priority encoder grants the lowest index.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_age_select
  import issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ID_W  = 8
) (
  input  logic [DEPTH-1:0]      sel_mask_i,
  input  logic [DEPTH*ID_W-1:0] ids_i,
  output logic [DEPTH-1:0]      grant_o,
  output logic                  any_o
);

  assign any_o = |sel_mask_i;

`ifdef ISSUE_QUEUE_AGE_SELECT_EN
  // Entry i is granted when it beats every other selectable entry. Equal IDs
  // never coexist in practice; if they did, the lower index wins so the
  // grant stays one-hot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_grant
    logic [DEPTH-1:0] w_beats;
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_cmp
      if (gi == gj) begin : g_self
        assign w_beats[gj] = 1'b1;
      end else if (gj < gi) begin : g_lower
        assign w_beats[gj] = !sel_mask_i[gj] ||
                             id_older(iq_id_wide_t'(ids_i[gi*ID_W +: ID_W]),
                                      iq_id_wide_t'(ids_i[gj*ID_W +: ID_W]), ID_W);
      end else begin : g_higher
        assign w_beats[gj] = !sel_mask_i[gj] ||
                             !id_older(iq_id_wide_t'(ids_i[gj*ID_W +: ID_W]),
                                       iq_id_wide_t'(ids_i[gi*ID_W +: ID_W]), ID_W);
      end
    end
    assign grant_o[gi] = sel_mask_i[gi] && (&w_beats);
  end
`else
  // IDs are irrelevant to the fixed-priority grant.
  logic w_unused_ids;
  assign w_unused_ids = ^ids_i;

  // Isolate the lowest set bit of the selectable mask.
  assign grant_o = sel_mask_i & (~sel_mask_i + {{(DEPTH-1){1'b0}}, 1'b1});
`endif

endmodule

`default_nettype wire

// File: rtl/issue_queue.sv
// ============================================================================
// issue_queue
// Out-of-order issue queue: holds up to DEPTH renamed instructions, tracks
// source readiness via wakeup broadcasts, issues one selectable entry per
// cycle into a registered valid/ready output and kills younger entries on a
// mispredict flush.
// Optional macro: ISSUE_QUEUE_AGE_SELECT_EN (oldest-first select; default is
// lowest-index priority select).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PREG_W     = 6,
  parameter int unsigned ID_W       = 8,
  parameter int unsigned WAKE_PORTS = 2,
  parameter int unsigned PAYLOAD_W  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [ID_W-1:0]              disp_id,
  input  logic [PAYLOAD_W-1:0]         disp_payload,
  input  logic                         disp_uses_rs,
  input  logic                         disp_uses_rt,
  input  logic [PREG_W-1:0]            disp_rs,
  input  logic [PREG_W-1:0]            disp_rt,
  input  logic                         disp_rs_rdy,
  input  logic                         disp_rt_rdy,
  input  logic [WAKE_PORTS-1:0]        wake_valid,
  input  logic [WAKE_PORTS*PREG_W-1:0] wake_preg,
  input  logic                         flush,
  input  logic [ID_W-1:0]              flush_id,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [ID_W-1:0]              iss_id,
  output logic [PAYLOAD_W-1:0]         iss_payload,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                 valid;
    logic [ID_W-1:0]      id;
    logic [PAYLOAD_W-1:0] payload;
    logic                 rs_used;
    logic [PREG_W-1:0]    rs_tag;
    logic                 rs_rdy;
    logic                 rt_used;
    logic [PREG_W-1:0]    rt_tag;
    logic                 rt_rdy;
  } iq_entry_t;

  iq_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic                  iss_valid_q, iss_valid_d;
  logic [ID_W-1:0]       iss_id_q, iss_id_d;
  logic [PAYLOAD_W-1:0]  iss_payload_q, iss_payload_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [DEPTH-1:0]      w_valid;
  logic [DEPTH-1:0]      w_selectable;
  logic [DEPTH-1:0]      w_grant;
  logic [DEPTH-1:0]      w_free_1h;
  logic [DEPTH-1:0]      w_kill;
  logic [DEPTH*ID_W-1:0] w_ids;
  logic                  w_any;
  logic                  w_disp_fire;
  logic                  w_load;
  logic                  w_drop;
  logic [ID_W-1:0]       w_sel_id;
  logic [PAYLOAD_W-1:0]  w_sel_payload;

  // True when any active wake port broadcasts this tag.
  function automatic logic wake_hit(input logic [PREG_W-1:0]            tag,
                                    input logic [WAKE_PORTS-1:0]        vld,
                                    input logic [WAKE_PORTS*PREG_W-1:0] pregs);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < int'(WAKE_PORTS); k++) begin
      hit = hit | (vld[k] && (pregs[k*PREG_W +: PREG_W] == tag));
    end
    return hit;
  endfunction

  // An ID is killed when it is strictly younger than the flush point.
  function automatic logic younger_than(input logic [ID_W-1:0] id,
                                        input logic [ID_W-1:0] fid);
    return id_older(iq_id_wide_t'(fid), iq_id_wide_t'(id), ID_W);
  endfunction

  assign disp_ready  = (count_q < CNT_W'(DEPTH)) && !flush;
  assign w_disp_fire = disp_valid && disp_ready;
  assign w_load      = !iss_valid_q || iss_ready;
  assign w_free_1h   = ~w_valid & (w_valid + {{(DEPTH-1){1'b0}}, 1'b1});

  // Per-entry status vectors feeding select, flush kill and slot allocation.
  always_comb begin
    w_valid      = '0;
    w_selectable = '0;
    w_kill       = '0;
    w_ids        = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_valid[i]              = ent_q[i].valid;
      w_selectable[i]         = ent_q[i].valid &&
                                (ent_q[i].rs_rdy || !ent_q[i].rs_used) &&
                                (ent_q[i].rt_rdy || !ent_q[i].rt_used);
      w_kill[i]               = flush && younger_than(ent_q[i].id, flush_id);
      w_ids[i*ID_W +: ID_W]   = ent_q[i].id;
    end
  end

  iq_age_select #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_select (
    .sel_mask_i (w_selectable),
    .ids_i      (w_ids),
    .grant_o    (w_grant),
    .any_o      (w_any)
  );

  // One-hot mux of the granted entry's ID and payload.
  always_comb begin
    w_sel_id      = '0;
    w_sel_payload = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_sel_id      = w_sel_id | ({ID_W{w_grant[i]}} & ent_q[i].id);
      w_sel_payload = w_sel_payload | ({PAYLOAD_W{w_grant[i]}} & ent_q[i].payload);
    end
  end

  assign w_drop = flush && younger_than(w_sel_id, flush_id);

  // Entry array next state: wakeup, free on issue, flush kill, dispatch write.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_q[i].valid) begin
        if (ent_q[i].rs_used && wake_hit(ent_q[i].rs_tag, wake_valid, wake_preg)) begin
          ent_d[i].rs_rdy = 1'b1;
        end
        if (ent_q[i].rt_used && wake_hit(ent_q[i].rt_tag, wake_valid, wake_preg)) begin
          ent_d[i].rt_rdy = 1'b1;
        end
      end
      if ((w_load && w_grant[i]) || w_kill[i]) begin
        ent_d[i].valid = 1'b0;
      end
      if (w_disp_fire && w_free_1h[i]) begin
        ent_d[i].valid   = 1'b1;
        ent_d[i].id      = disp_id;
        ent_d[i].payload = disp_payload;
        ent_d[i].rs_used = disp_uses_rs;
        ent_d[i].rs_tag  = disp_rs;
        ent_d[i].rs_rdy  = !disp_uses_rs || disp_rs_rdy ||
                           wake_hit(disp_rs, wake_valid, wake_preg);
        ent_d[i].rt_used = disp_uses_rt;
        ent_d[i].rt_tag  = disp_rt;
        ent_d[i].rt_rdy  = !disp_uses_rt || disp_rt_rdy ||
                           wake_hit(disp_rt, wake_valid, wake_preg);
      end
    end
  end

  // Issue register next state; a selected entry younger than the flush point
  // is freed but never presented.
  always_comb begin
    iss_valid_d   = iss_valid_q;
    iss_id_d      = iss_id_q;
    iss_payload_d = iss_payload_q;
    if (w_load) begin
      iss_valid_d = w_any && !w_drop;
      if (w_any) begin
        iss_id_d      = w_sel_id;
        iss_payload_d = w_sel_payload;
      end
    end else if (flush && younger_than(iss_id_q, flush_id)) begin
      iss_valid_d = 1'b0;
    end
  end

  // Occupancy is the population count of the next entry array.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_d = count_d + CNT_W'(ent_d[i].valid);
    end
  end

  // State registers; reset discards every entry immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q         <= '0;
      iss_valid_q   <= 1'b0;
      iss_id_q      <= '0;
      iss_payload_q <= '0;
      count_q       <= '0;
    end else begin
      ent_q         <= ent_d;
      iss_valid_q   <= iss_valid_d;
      iss_id_q      <= iss_id_d;
      iss_payload_q <= iss_payload_d;
      count_q       <= count_d;
    end
  end

  assign iss_valid   = iss_valid_q;
  assign iss_id      = iss_id_q;
  assign iss_payload = iss_payload_q;
  assign count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_queue.sv
`timescale 1ns/1ps
`default_nettype none

module tb_issue_queue;

  localparam int DEPTH = 16;
  localparam int PREG_W = 6;
  localparam int ID_W = 8;
  localparam int WP = 2;
  localparam int PW = 64;
`ifdef ISSUE_QUEUE_AGE_SELECT_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            disp_valid, disp_ready, disp_uses_rs, disp_uses_rt;
  logic            disp_rs_rdy, disp_rt_rdy, flush, iss_valid, iss_ready;
  logic [ID_W-1:0] disp_id, flush_id, iss_id;
  logic [PW-1:0]   disp_payload, iss_payload;
  logic [PREG_W-1:0] disp_rs, disp_rt;
  logic [WP-1:0]   wake_valid;
  logic [WP*PREG_W-1:0] wake_preg;
  logic [4:0]      count;

  issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ID_W(ID_W), .WAKE_PORTS(WP), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_id(disp_id),
    .disp_payload(disp_payload), .disp_uses_rs(disp_uses_rs), .disp_uses_rt(disp_uses_rt),
    .disp_rs(disp_rs), .disp_rt(disp_rt), .disp_rs_rdy(disp_rs_rdy), .disp_rt_rdy(disp_rt_rdy),
    .wake_valid(wake_valid), .wake_preg(wake_preg), .flush(flush), .flush_id(flush_id),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_id(iss_id), .iss_payload(iss_payload),
    .count(count)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v; bit [7:0] id; bit [63:0] pl;
    bit rs_used; bit [5:0] rs; bit rs_ok;
    bit rt_used; bit [5:0] rt; bit rt_ok;
  } ment_t;

  ment_t     m [DEPTH];
  bit        m_iv;
  bit [7:0]  m_iid;
  bit [63:0] m_ipl;
  bit        last_acc;
  bit [7:0]  next_id;
  bit [7:0]  hs_q [$];
  int        n_checks = 0;
  int        n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
  endtask

  // a is strictly younger than f when (a - f) mod 256 lies in 1..127
  function automatic bit younger(input bit [7:0] a, input bit [7:0] f);
    int d;
    d = (int'(a) - int'(f) + 256) % 256;
    return (d >= 1) && (d <= 127);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].v) c++;
    return c;
  endfunction

  function automatic bit woken(input bit [5:0] tag);
    for (int k = 0; k < WP; k++)
      if (wake_valid[k] && (wake_preg[k*PREG_W +: PREG_W] == tag)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick();
    int best = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v && m[i].rs_ok && m[i].rt_ok) begin
        if (best < 0) best = i;
        else if (AGE && younger(m[best].id, m[i].id)) best = i;
      end
    end
    return best;
  endfunction

  function automatic bit span_ok();
    for (int i = 0; i < DEPTH; i++)
      if (m[i].v && (int'(8'(next_id - m[i].id)) >= 100)) return 1'b0;
    if (m_iv && (int'(8'(next_id - m_iid)) >= 100)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = '{default: 0};
    m_iv = 0; m_iid = 0; m_ipl = 0;
  endtask

  task automatic compare();
    check("iss_valid", iss_valid, m_iv);
    if (m_iv) begin
      check("iss_id", iss_id, m_iid);
      check("iss_payload", iss_payload, m_ipl);
    end
    check("count", count, m_count());
  endtask

  task automatic idle();
    disp_valid = 0; disp_id = 0; disp_payload = 0; disp_uses_rs = 0; disp_uses_rt = 0;
    disp_rs = 0; disp_rt = 0; disp_rs_rdy = 0; disp_rt_rdy = 0;
    wake_valid = 0; wake_preg = 0; flush = 0; flush_id = 0;
  endtask

  task automatic disp(input bit [7:0] id, input bit urs, input bit [5:0] rs, input bit rsr,
                      input bit urt, input bit [5:0] rt, input bit rtr);
    disp_valid = 1; disp_id = id; disp_payload = {$urandom, $urandom};
    disp_uses_rs = urs; disp_rs = rs; disp_rs_rdy = rsr;
    disp_uses_rt = urt; disp_rt = rt; disp_rt_rdy = rtr;
  endtask

  // One clock: inputs are already driven; advance the model and compare.
  task automatic step();
    ment_t nx [DEPTH];
    bit niv; bit [7:0] niid; bit [63:0] nipl;
    int sel; int slot;
    #1;
    check("disp_ready", disp_ready, (m_count() < DEPTH) && !flush);
    if (iss_valid && iss_ready) hs_q.push_back(iss_id);
    sel = pick();
    nx = m; niv = m_iv; niid = m_iid; nipl = m_ipl;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v && m[i].rs_used && woken(m[i].rs)) nx[i].rs_ok = 1;
      if (m[i].v && m[i].rt_used && woken(m[i].rt)) nx[i].rt_ok = 1;
    end
    if (!m_iv || iss_ready) begin
      if (sel >= 0) begin
        nx[sel].v = 0; niid = m[sel].id; nipl = m[sel].pl;
        niv = !(flush && younger(m[sel].id, flush_id));
      end else niv = 0;
    end else if (flush && m_iv && younger(m_iid, flush_id)) niv = 0;
    if (flush) for (int i = 0; i < DEPTH; i++) if (younger(nx[i].id, flush_id)) nx[i].v = 0;
    last_acc = 0;
    if (disp_valid && (m_count() < DEPTH) && !flush) begin
      slot = -1;
      for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].v) slot = i;
      nx[slot] = '{v: 1, id: disp_id, pl: disp_payload,
                   rs_used: disp_uses_rs, rs: disp_rs,
                   rs_ok: !disp_uses_rs || disp_rs_rdy || woken(disp_rs),
                   rt_used: disp_uses_rt, rt: disp_rt,
                   rt_ok: !disp_uses_rt || disp_rt_rdy || woken(disp_rt)};
      last_acc = 1;
    end
    @(posedge clk); #1;
    m = nx; m_iv = niv; m_iid = niid; m_ipl = nipl;
    compare();
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      idle(); iss_ready = 1; wake_valid = 2'b11;
      wake_preg = {6'((c + 32) % 64), 6'(c % 64)};
      step();
      if (m_count() == 0 && !m_iv) done = 1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s_drain: actual not_empty required empty", name);
    end
  endtask

  task automatic check_hs(input string name, input int idx, input int exp);
    check(name, (idx < hs_q.size()) ? 64'(hs_q[idx]) : 64'hdead, exp);
  endtask

  localparam int P5_SECOND = AGE ? 31 : 32;
  localparam int P6_PICK   = AGE ? 9 : 10;

  initial begin
    idle(); iss_ready = 0; model_reset();
    // ---- reset ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_iss_valid", iss_valid, 0);
    check("rst_iss_id", iss_id, 0);
    check("rst_iss_payload", iss_payload, 0);
    check("rst_count", count, 0);
    rst = 0;
    #1 check("rst_disp_ready", disp_ready, 1);

    // ---- in-order stream 1..16, all ready ----
    hs_q.delete(); iss_ready = 1;
    for (int id = 1; id <= 16; id++) begin
      idle(); disp(8'(id), 1, 6'd3, 1, 0, 0, 0); step();
    end
    for (int i = 0; i < 4; i++) begin idle(); step(); end
    for (int i = 0; i < 16; i++) check_hs("p1_order", i, i + 1);
    check("p1_count", count, 0);

    // ---- wakeup ordering ----
    hs_q.delete(); iss_ready = 1;
    idle(); disp(8'd5, 1, 6'd12, 0, 0, 0, 0); step();
    idle(); disp(8'd6, 1, 6'd13, 1, 0, 0, 0); step();
    idle(); step();
    idle(); wake_valid = 2'b10; wake_preg = {6'd12, 6'd0}; step();
    idle(); step();
    check("p2_iss_valid", iss_valid, 1);
    check("p2_iss_id", iss_id, 5);
    idle(); step();
    check_hs("p2_first", 0, 6);
    check_hs("p2_second", 1, 5);
    drain("p2");

    // ---- same-cycle wakeup bypass ----
    iss_ready = 1;
    idle(); disp(8'd20, 1, 6'd7, 0, 0, 0, 0); wake_valid = 2'b01; wake_preg = {6'd0, 6'd7}; step();
    idle(); step();
    check("p3_iss_valid", iss_valid, 1);
    check("p3_iss_id", iss_id, 20);
    drain("p3");

    // ---- ID wrap and flush ----
    iss_ready = 0;
    for (int k = 0; k < 10; k++) begin
      idle(); disp(8'(250 + k), 1, 6'd40, 0, 0, 0, 0); step();
    end
    check("p4_count_full10", count, 10);
    idle(); flush = 1; flush_id = 8'd254; step();
    check("p4_count_after_flush", count, 5);
    check("p4_iss_valid", iss_valid, 0);
    hs_q.delete();
    drain("p4");
    for (int i = 0; i < 5; i++) check_hs("p4_survivor", i, 250 + i);

    // ---- backpressure ----
    hs_q.delete(); iss_ready = 0;
    for (int k = 0; k < 3; k++) begin idle(); disp(8'(30 + k), 0, 0, 0, 0, 0, 0); step(); end
    for (int k = 0; k < 10; k++) begin
      idle(); step();
      check("p5_hold_id", iss_id, 30);
      check("p5_hold_count", count, 2);
    end
    drain("p5");
    check_hs("p5_first", 0, 30);
    check_hs("p5_second", 1, P5_SECOND);

    // ---- slot reuse: priority vs age ----
    iss_ready = 0;
    idle(); disp(8'd4, 0, 0, 0, 0, 0, 0); step();
    idle(); disp(8'd5, 1, 6'd41, 0, 0, 0, 0); step();
    idle(); disp(8'd6, 1, 6'd42, 0, 0, 0, 0); step();
    idle(); disp(8'd7, 1, 6'd42, 0, 0, 0, 0); step();
    idle(); disp(8'd9, 0, 0, 0, 0, 0, 0); step();
    idle(); wake_valid = 2'b01; wake_preg = {6'd0, 6'd41}; step();
    idle(); iss_ready = 1; step();
    check("p6_iss_id_5", iss_id, 5);
    idle(); iss_ready = 0; disp(8'd10, 0, 0, 0, 0, 0, 0); step();
    idle(); iss_ready = 1; step();
    check("p6_pick", iss_id, P6_PICK);
    drain("p6");

    // ---- randomized ----
    next_id = 8'd100;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit stall;
      stall = ((cyc / 150) % 3) == 2;
      idle();
      iss_ready = stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        flush = 1; flush_id = next_id - 8'(1 + $urandom_range(0, 6));
      end
      if ($urandom_range(0, 9) < 7 && span_ok())
        disp(next_id, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < WP; k++) begin
        wake_valid[k] = ($urandom_range(0, 9) < 3);
        wake_preg[k*PREG_W +: PREG_W] = 6'($urandom_range(0, 7));
      end
      step();
      if (flush) next_id = flush_id + 8'd1;
      else if (last_acc) next_id = next_id + 8'd1;
    end

    // ---- asynchronous reset mid-operation ----
    idle(); iss_ready = 0; disp(next_id, 0, 0, 0, 0, 0, 0);
    step();
    idle();
    #2 rst = 1;
    #1;
    check("arst_count", count, 0);
    check("arst_iss_valid", iss_valid, 0);
    @(posedge clk); #1 rst = 0;
    model_reset();
    idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
